// File: rtl/pixel_pkg.sv
// Shared scan-state encoding, default raster geometry and coordinate/offset types
// for the pixel scan path.
package pixel_pkg;

  localparam int SCREEN_W_DEFAULT          = 640;
  localparam int SCREEN_H_DEFAULT          = 480;
  localparam int PIXEL_DATA_WIDTH_DEFAULT  = 10;
  localparam int ENGINE_DATA_WIDTH_DEFAULT = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  typedef logic [PIXEL_DATA_WIDTH_DEFAULT-1:0]         pixel_coord_t;
  typedef logic signed [ENGINE_DATA_WIDTH_DEFAULT-1:0] fixed_t;

endpackage

// File: rtl/pixel_raster_counter.sv
// Raster x/y counter: x wraps at SCREEN_W-1 and carries into y, which wraps at SCREEN_H-1.
// clr has priority over inc. last_pixel flags (SCREEN_W-1, SCREEN_H-1) combinationally from the registers.
module pixel_raster_counter
  import pixel_pkg::*;
#(
  parameter int SCREEN_W         = SCREEN_W_DEFAULT,
  parameter int SCREEN_H         = SCREEN_H_DEFAULT,
  parameter int PIXEL_DATA_WIDTH = PIXEL_DATA_WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        inc,
  output logic [PIXEL_DATA_WIDTH-1:0] pixel_x,
  output logic [PIXEL_DATA_WIDTH-1:0] pixel_y,
  output logic                        last_pixel
);

  localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST = PIXEL_DATA_WIDTH'(SCREEN_W - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST = PIXEL_DATA_WIDTH'(SCREEN_H - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] ONE    = PIXEL_DATA_WIDTH'(1);

  logic x_last;

  assign x_last     = (pixel_x == X_LAST);
  assign last_pixel = x_last && (pixel_y == Y_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (clr) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (inc) begin
      if (x_last) begin
        pixel_x <= '0;
        pixel_y <= (pixel_y == Y_LAST) ? '0 : pixel_y + ONE;
      end else begin
        pixel_x <= pixel_x + ONE;
      end
    end
  end

endmodule

// File: rtl/pixel_scan_ctrl.sv
// Frame scan sequencer for pixel_map: raster coordinates advance only when map_en, ~full_queue and ~distributor_ready hold, else everything holds.
// View config is shadowed once per frame; PIXEL_SCAN_AUTO_RESTART_EN makes DRAIN loop back into SCAN until abort.
module pixel_scan_ctrl
  import pixel_pkg::*;
#(
  parameter int SCREEN_W          = SCREEN_W_DEFAULT,
  parameter int SCREEN_H          = SCREEN_H_DEFAULT,
  parameter int PIXEL_DATA_WIDTH  = PIXEL_DATA_WIDTH_DEFAULT,
  parameter int ENGINE_DATA_WIDTH = ENGINE_DATA_WIDTH_DEFAULT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                full_queue,
  input  logic                                distributor_ready,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] x_offset_in,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] y_offset_in,
  input  logic [31:0]                         zoom_in,
  output logic                                map_en,
  output logic [PIXEL_DATA_WIDTH-1:0]         pixel_x,
  output logic [PIXEL_DATA_WIDTH-1:0]         pixel_y,
  output logic signed [ENGINE_DATA_WIDTH-1:0] x_offset,
  output logic signed [ENGINE_DATA_WIDTH-1:0] y_offset,
  output logic [31:0]                         zoom,
  output logic                                busy,
  output logic                                frame_done,
  output logic [15:0]                         frame_count
);

  scan_state_t state_q, state_d;

  logic map_en_d;
  logic busy_d;
  logic frame_done_d;
  logic latch_cfg;
  logic coord_clr;
  logic coord_inc;
  logic last_pixel;
  logic advance;

  // Must match pixel_map's capture qualifier exactly so no coordinate is skipped or repeated.
  assign advance = map_en & ~full_queue & ~distributor_ready;

  pixel_raster_counter #(
    .SCREEN_W         (SCREEN_W),
    .SCREEN_H         (SCREEN_H),
    .PIXEL_DATA_WIDTH (PIXEL_DATA_WIDTH)
  ) u_raster (
    .clk        (clk),
    .reset      (reset),
    .clr        (coord_clr),
    .inc        (coord_inc),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .last_pixel (last_pixel)
  );

  always_comb begin
    state_d      = state_q;
    map_en_d     = map_en;
    busy_d       = busy;
    frame_done_d = 1'b0;
    latch_cfg    = 1'b0;
    coord_clr    = 1'b0;
    coord_inc    = 1'b0;

    if (abort) begin
      state_d   = IDLE;
      map_en_d  = 1'b0;
      busy_d    = 1'b0;
      coord_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = SCAN;
            map_en_d  = 1'b1;
            busy_d    = 1'b1;
            latch_cfg = 1'b1;
            coord_clr = 1'b1;
          end
        end
        SCAN: begin
          if (advance) begin
            coord_inc = 1'b1;
            // The counter wraps itself back to (0,0) on this final increment.
            if (last_pixel) begin
              state_d  = DRAIN;
              map_en_d = 1'b0;
            end
          end
        end
        DRAIN: begin
          frame_done_d = 1'b1;
`ifdef PIXEL_SCAN_AUTO_RESTART_EN
          state_d   = SCAN;
          map_en_d  = 1'b1;
          busy_d    = 1'b1;
          latch_cfg = 1'b1;
          coord_clr = 1'b1;
`else
          state_d   = IDLE;
          busy_d    = 1'b0;
`endif
        end
        default: begin
          state_d   = IDLE;
          map_en_d  = 1'b0;
          busy_d    = 1'b0;
          coord_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      map_en      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q    <= state_d;
      map_en     <= map_en_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      if (frame_done_d) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_offset <= '0;
      y_offset <= '0;
      zoom     <= '0;
    end else if (latch_cfg) begin
      x_offset <= x_offset_in;
      y_offset <= y_offset_in;
      zoom     <= zoom_in;
    end
  end

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Directed bench for pixel_scan_ctrl on a 4x3 raster; expected values are hand-derived
// from the scan order, stall rules and frame-shadow behaviour.
module tb_pixel_scan_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 10;
  localparam int EW = 25;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic                 abort;
  logic                 full_queue;
  logic                 distributor_ready;
  logic signed [EW-1:0] x_offset_in;
  logic signed [EW-1:0] y_offset_in;
  logic [31:0]          zoom_in;
  logic                 map_en;
  logic [PW-1:0]        pixel_x;
  logic [PW-1:0]        pixel_y;
  logic signed [EW-1:0] x_offset;
  logic signed [EW-1:0] y_offset;
  logic [31:0]          zoom;
  logic                 busy;
  logic                 frame_done;
  logic [15:0]          frame_count;

  int total = 0;
  int bad   = 0;

  pixel_scan_ctrl #(
    .SCREEN_W          (W),
    .SCREEN_H          (H),
    .PIXEL_DATA_WIDTH  (PW),
    .ENGINE_DATA_WIDTH (EW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .full_queue        (full_queue),
    .distributor_ready (distributor_ready),
    .x_offset_in       (x_offset_in),
    .y_offset_in       (y_offset_in),
    .zoom_in           (zoom_in),
    .map_en            (map_en),
    .pixel_x           (pixel_x),
    .pixel_y           (pixel_y),
    .x_offset          (x_offset),
    .y_offset          (y_offset),
    .zoom              (zoom),
    .busy              (busy),
    .frame_done        (frame_done),
    .frame_count       (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_coord(input string tag, input int idx);
    chk({tag, "_x"}, 32'(pixel_x), 32'(idx % W));
    chk({tag, "_y"}, 32'(pixel_y), 32'(idx / W));
  endtask

  initial begin
    int idx;
    int hold;

    reset             = 1'b0;
    start             = 1'b0;
    abort             = 1'b0;
    full_queue        = 1'b0;
    distributor_ready = 1'b0;
    x_offset_in       = 25'sh0100000;
    y_offset_in       = 25'sh0080000;
    zoom_in           = 32'h0002_0000;
    #2;
    chk("rst_map_en", 32'(map_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk_coord("rst", 0);
    chk("rst_xoff", 32'(x_offset), 32'd0);
    chk("rst_zoom", zoom, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick;
    chk("idle_busy", 32'(busy), 32'd0);

`ifdef PIXEL_SCAN_AUTO_RESTART_EN
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < W * H; i++) begin
        chk("ar_map_en", 32'(map_en), 32'd1);
        chk_coord("ar", i);
        if (i == W * H - 1)
          chk("ar_xoff", 32'(x_offset), (f == 0) ? 32'h0100000 : 32'h0200000);
        if (f == 0 && i == 4) x_offset_in = 25'sh0200000;
        tick;
      end
      chk("ar_drain_map_en", 32'(map_en), 32'd0);
      chk("ar_drain_done", 32'(frame_done), 32'd0);
      tick;
      chk("ar_done", 32'(frame_done), 32'd1);
      chk("ar_restart_map_en", 32'(map_en), 32'd1);
      chk_coord("ar_restart", 0);
      chk("ar_count", 32'(frame_count), 32'(f + 1));
      chk("ar_busy", 32'(busy), 32'd1);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ar_abort_busy", 32'(busy), 32'd0);
    chk("ar_abort_done", 32'(frame_done), 32'd0);
    chk("ar_abort_count", 32'(frame_count), 32'd3);
`else
    // Unstalled frame: 12 consecutive coordinates, then drain, then done.
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_xoff", 32'(x_offset), 32'h0100000);
    chk("t1_yoff", 32'(y_offset), 32'h0080000);
    chk("t1_zoom", zoom, 32'h0002_0000);
    for (int i = 0; i < W * H; i++) begin
      chk("t1_map_en", 32'(map_en), 32'd1);
      chk_coord("t1", i);
      tick;
    end
    chk("t1_drain_map_en", 32'(map_en), 32'd0);
    chk("t1_drain_done", 32'(frame_done), 32'd0);
    chk("t1_drain_busy", 32'(busy), 32'd1);
    tick;
    chk("t1_done", 32'(frame_done), 32'd1);
    chk("t1_count", 32'(frame_count), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);
    tick;
    chk("t1_done_pulse", 32'(frame_done), 32'd0);

    // Stall 5 cycles at (2,1) while the offset request changes mid-frame.
    start = 1'b1;
    tick;
    start = 1'b0;
    idx  = 0;
    hold = 0;
    for (int c = 0; c < 40 && idx < W * H; c++) begin
      chk("t2_map_en", 32'(map_en), 32'd1);
      chk_coord("t2", idx);
      if (idx == 6 && hold < 5) begin
        full_queue  = 1'b1;
        x_offset_in = 25'sh0200000;
        hold++;
      end else begin
        full_queue = 1'b0;
        idx++;
      end
      tick;
    end
    full_queue = 1'b0;
    chk("t2_end_map_en", 32'(map_en), 32'd0);
    chk("t3_xoff_held", 32'(x_offset), 32'h0100000);
    tick;
    chk("t2_done", 32'(frame_done), 32'd1);
    chk("t2_count", 32'(frame_count), 32'd2);

    // New request takes effect at the next start; then abort at (1,1).
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t3_xoff_new", 32'(x_offset), 32'h0200000);
    repeat (5) tick;
    chk_coord("t4_pre", 5);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_map_en", 32'(map_en), 32'd0);
    chk_coord("t4", 0);
    chk("t4_done", 32'(frame_done), 32'd0);
    chk("t4_count", 32'(frame_count), 32'd2);
    tick;
    chk("t4_done_late", 32'(frame_done), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    chk("t4_sa_busy", 32'(busy), 32'd0);
    chk("t4_sa_map_en", 32'(map_en), 32'd0);
    tick;
    chk("t4_sa_busy2", 32'(busy), 32'd0);

    // Async reset mid-scan at (2,2), then a full recovery frame.
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    chk_coord("t5_pre", 10);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_map_en", 32'(map_en), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(frame_done), 32'd0);
    chk("t5_count", 32'(frame_count), 32'd0);
    chk_coord("t5", 0);
    chk("t5_xoff", 32'(x_offset), 32'd0);
    chk("t5_zoom", zoom, 32'd0);
    #3;
    reset = 1'b1;
    tick;
    chk("t5_rel_busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t5_rec_map_en", 32'(map_en), 32'd1);
    chk("t5_rec_xoff", 32'(x_offset), 32'h0200000);
    distributor_ready = 1'b1;
    tick;
    tick;
    chk_coord("t5_dist_hold", 0);
    distributor_ready = 1'b0;
    for (int i = 0; i < W * H; i++) begin
      chk_coord("t5_rec", i);
      tick;
    end
    tick;
    chk("t5_rec_done", 32'(frame_done), 32'd1);
    chk("t5_rec_count", 32'(frame_count), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
